pc_call_stack: RTL
==================

Name: pc_call_stack

Overview:
- Parametrised successor to the CPU program counter.
- Holds the instruction address and supports increment, jump, and subroutine call/return through an internal LIFO return-address stack of configurable depth.
- Sits between the control unit (which drives the one-hot-style strobes) and the shared CPU bus. The bus-facing output is zero when not enabled, so the top level can OR/mux it onto the bus.
- Clocked by the CPU clock from the clock unit.

Parameters:
- WIDTH, 8, address width in bits (PC, bus_in, bus_out, stack entries).
- DEPTH, 4, number of return-address stack entries (≥1).
- RESET_ADDR, 0, PC value loaded on reset.

Ports:
- clk  input  1  CPU clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inc  input  1  increment PC.
- jump  input  1  load PC from bus_in.
- call  input  1  push return address (PC+1) and load PC from bus_in.
- ret  input  1  pop top of stack into PC.
- out  input  1  drive PC onto bus_out.
- clear_err  input  1  clear sticky error flags.
- bus_in  input  WIDTH  jump/call target from CPU bus.
- bus_out  output  WIDTH  PC when out=1, else all zeros (combinational).
- pc  output  WIDTH  current PC, always visible (debug/LEDs).
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  depth==DEPTH.
- empty  output  1  depth==0.
- overflow  output  1  sticky: call attempted while full.
- underflow  output  1  sticky: ret attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately and regardless of clk):
  - pc=RESET_ADDR, depth=0, overflow=0, underflow=0.
  - Stack contents are don't-care.
  - full=0, empty=1; bus_out=0 if out=0.
- Reset deasserted mid-sequence: the first rising edge after release behaves normally. No pending operation survives reset.
- Per rising edge, exactly one operation takes effect. Fixed priority is ret > call > jump > inc > hold; lower-priority strobes in the same cycle are ignored.
- ret:
  - If depth>0: pc ← stack[depth-1], depth ← depth-1.
  - If depth==0: pc holds, depth holds, underflow ← 1.
- call:
  - If depth<DEPTH: stack[depth] ← pc+1 (mod 2^WIDTH), depth ← depth+1, pc ← bus_in.
  - If full: no push, pc holds (call suppressed entirely), overflow ← 1.
- jump: pc ← bus_in; stack untouched.
- inc: pc ← pc+1, wrapping from 2^WIDTH−1 to 0 with no flag.
- No strobe: all state holds.
- Latency: one cycle. The new pc is visible on pc/bus_out after the edge on which the strobe was sampled.
- bus_out is purely combinational from out and registered pc. There is no tristate.
- full, empty and depth are combinational from the registered depth.
- clear_err:
  - Synchronous: overflow ← 0, underflow ← 0.
  - If an error event occurs in the same cycle, the set wins (flag ends at 1).
  - clear_err does not affect pc or the stack.
- Call/return address wrap: a call from pc=2^WIDTH−1 pushes 0.
- All strobes are sampled synchronously. They are required to be stable around the clk edge; the block does no synchronisation or edge detection.

Test Plan:
- Reset and inc: rst_n=0 then release, inc=1 for 3 edges → pc=0,1,2,3; out=1 → bus_out=3; out=0 → bus_out=0; empty=1, depth=0.
- Inc wrap: jump with bus_in=8'hFF, then inc → pc=8'h00, no error flags.
- Nested call/ret:
  - From pc=8'h10: call bus_in=8'h40 → pc=8'h40, depth=1.
  - inc → pc=8'h41; call bus_in=8'h80 → pc=8'h80, depth=2.
  - ret → pc=8'h42, depth=1; ret → pc=8'h11, depth=0.
- Overflow: DEPTH=4, five calls → after 4th, full=1; 5th call leaves pc at 4th target, depth=4, overflow=1. Then clear_err → overflow=0.
- Underflow/priority:
  - With depth=0, ret=1 with call=1 → ret wins, pc holds, underflow=1, depth=0.
  - jump=1 with inc=1 and bus_in=8'h22 → pc=8'h22.
- Async reset mid-operation: depth=2, pc=8'h80, drop rst_n between clock edges → pc=RESET_ADDR and depth=0 immediately, before the next edge. Next ret sets underflow.

Source files
------------

// File: rtl/pc_call_stack.sv
// Program counter with increment, jump and call/return through a LIFO
// return-address stack; sticky overflow/underflow flags for misuse of the stack.
module pc_call_stack #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc,
  input  logic                       jump,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       out,
  input  logic                       clear_err,
  input  logic [WIDTH-1:0]           bus_in,
  output logic [WIDTH-1:0]           bus_out,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push;
  logic [WIDTH-1:0] pc_inc;
  logic [IW-1:0]    top_idx, push_idx;
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign pc_inc   = pc_q + 1'b1;
  assign top_idx  = IW'(depth_q - 1'b1);
  assign push_idx = IW'(depth_q);

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  // Fixed priority ret > call > jump > inc; error sets override clear_err.
  always_comb begin
    pc_d        = pc_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q & ~clear_err;
    underflow_d = underflow_q & ~clear_err;
    push        = 1'b0;
    if (ret) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        pc_d    = stack_q[top_idx];
        depth_d = depth_q - 1'b1;
      end
    end else if (call) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        push    = 1'b1;
        pc_d    = bus_in;
        depth_d = depth_q + 1'b1;
      end
    end else if (jump) begin
      pc_d = bus_in;
    end else if (inc) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_ADDR;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc        = pc_q;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign bus_out   = out ? pc_q : '0;

endmodule
